// File: rtl/router_pkg.sv
// Shared router types: flit format, buffer status and input-buffer RX states.
// The input buffer build option is ROUTER_IBUF_STATS_EN (see router_input_buffer).
package router_pkg;

  localparam int NUM_OF_PORTS    = 5;
  localparam int NUM_OF_FLITS    = 4;
  localparam int FLIT_DATA_BITS  = 16;
  localparam int FLIT_SIZE       = FLIT_DATA_BITS + 3;
  localparam int IBUF_DEPTH_PKTS = 2;

  typedef enum logic [1:0] {
    NONE_FLIT = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic                      valid;
    FLIT_TYPE_t                flit_type;
    logic [FLIT_DATA_BITS-1:0] data;
  } FLIT_t;

  typedef enum logic [1:0] {
    PACKET_EMPTY    = 2'd0,
    PACKET_FILLING  = 2'd1,
    PACKET_RECEIVED = 2'd2,
    PACKET_SENT     = 2'd3
  } BUFFER_STATUS_t;

  typedef enum logic [1:0] {
    WAIT_HEAD  = 2'd0,
    WAIT_BODY1 = 2'd1,
    WAIT_BODY2 = 2'd2,
    WAIT_TAIL  = 2'd3
  } IBUF_RX_STATE_t;

  function automatic FLIT_TYPE_t ibuf_expected_type(input IBUF_RX_STATE_t s);
    case (s)
      WAIT_HEAD: return HEAD_FLIT;
      WAIT_TAIL: return TAIL_FLIT;
      default:   return BODY_FLIT;
    endcase
  endfunction

  // Flits of the partial packet already written when sitting in state s.
  function automatic logic [1:0] ibuf_partial_flits(input IBUF_RX_STATE_t s);
    case (s)
      WAIT_BODY1: return 2'd1;
      WAIT_BODY2: return 2'd2;
      WAIT_TAIL:  return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/router_ibuf_mem.sv
// Flit storage for the input buffer: one synchronous write port, one
// asynchronous read port, no reset on the array.
module router_ibuf_mem #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 19,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_input_buffer.sv
// Store-and-forward per-port input buffer with HEAD/BODY/BODY/TAIL checking.
// Define ROUTER_IBUF_STATS_EN to add saturating packet and error counters.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int DEPTH_PKTS = IBUF_DEPTH_PKTS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  FLIT_t                     in_flit,
  output logic                      in_ready,
  output FLIT_t                     out_flit,
  output logic                      out_req,
  input  logic                      out_ack,
  output logic [FLIT_DATA_BITS-1:0] route_addr,
  output BUFFER_STATUS_t            buf_status,
`ifdef ROUTER_IBUF_STATS_EN
  output logic [15:0]               stat_pkts_rx,
  output logic [15:0]               stat_err,
`endif
  output logic                      err_seq
);

  localparam int DEPTH = DEPTH_PKTS * NUM_OF_FLITS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  // Handshakes: a flit moves in when in_flit.valid && in_ready, and one flit
  // moves out when out_ack && out_req; neither side waits on the other.
  IBUF_RX_STATE_t   state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    pkt_start_q, pkt_start_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    free_q, free_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [1:0]       rd_idx_q, rd_idx_d;
  logic             sent_q, sent_d;
  logic             err_q, err_d;

  FLIT_TYPE_t       exp_type;
  logic             accept;
  logic             type_ok;
  logic             pop;
  logic             tail_pop;
  logic             tail_acc;
  logic [CW-1:0]    n_written;
  logic [CW-1:0]    n_restored;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [FLIT_SIZE-1:0] mem_rdata;

  // Space for a whole packet is reserved when its head is taken, so only
  // WAIT_HEAD looks at the free count.
  always_comb begin
    exp_type = ibuf_expected_type(state_q);
    in_ready = rst_n && ((state_q != WAIT_HEAD) || (free_q >= CW'(NUM_OF_FLITS)));
  end

  assign accept   = in_flit.valid && in_ready;
  assign type_ok  = (in_flit.flit_type == exp_type);
  assign pop      = out_ack && out_req;
  assign tail_pop = pop && (rd_idx_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    n_written   = '0;
    n_restored  = '0;
    err_d       = 1'b0;
    tail_acc    = 1'b0;
    if (accept) begin
      if (type_ok) begin
        mem_we    = 1'b1;
        n_written = CW'(1);
        wr_ptr_d  = wr_ptr_q + AW'(1);
        case (state_q)
          WAIT_HEAD:  state_d = WAIT_BODY1;
          WAIT_BODY1: state_d = WAIT_BODY2;
          WAIT_BODY2: state_d = WAIT_TAIL;
          default: begin
            state_d     = WAIT_HEAD;
            tail_acc    = 1'b1;
            pkt_start_d = wr_ptr_q + AW'(1);
          end
        endcase
      end else begin
        // Rewind over the partial packet only; pkt_start_q always marks the
        // first slot after the last complete packet.
        err_d      = 1'b1;
        n_restored = CW'(ibuf_partial_flits(state_q));
        if (in_flit.flit_type == HEAD_FLIT) begin
          mem_we    = 1'b1;
          mem_waddr = pkt_start_q;
          n_written = CW'(1);
          wr_ptr_d  = pkt_start_q + AW'(1);
          state_d   = WAIT_BODY1;
        end else begin
          wr_ptr_d = pkt_start_q;
          state_d  = WAIT_HEAD;
        end
      end
    end
  end

  always_comb begin
    free_d    = free_q - n_written + n_restored + CW'(pop);
    pkt_cnt_d = pkt_cnt_q + CW'(tail_acc) - CW'(tail_pop);
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_idx_d  = pop ? rd_idx_q + 2'd1 : rd_idx_q;
    sent_d    = tail_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_HEAD;
      wr_ptr_q    <= '0;
      pkt_start_q <= '0;
      rd_ptr_q    <= '0;
      free_q      <= CW'(DEPTH);
      pkt_cnt_q   <= '0;
      rd_idx_q    <= '0;
      sent_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pkt_start_q <= pkt_start_d;
      rd_ptr_q    <= rd_ptr_d;
      free_q      <= free_d;
      pkt_cnt_q   <= pkt_cnt_d;
      rd_idx_q    <= rd_idx_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
    end
  end

  router_ibuf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (in_flit),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    out_req    = (pkt_cnt_q != '0);
    out_flit   = out_req ? FLIT_t'(mem_rdata) : '0;
    route_addr = (out_req && out_flit.flit_type == HEAD_FLIT) ? out_flit.data : '0;
    if (pkt_cnt_q != '0)             buf_status = PACKET_RECEIVED;
    else if (state_q != WAIT_HEAD)   buf_status = PACKET_FILLING;
    else if (sent_q)                 buf_status = PACKET_SENT;
    else                             buf_status = PACKET_EMPTY;
  end

  assign err_seq = err_q;

`ifdef ROUTER_IBUF_STATS_EN
  logic [15:0] stat_pkts_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (tail_acc && stat_pkts_q != 16'hFFFF) stat_pkts_q <= stat_pkts_q + 16'd1;
      if (err_d && stat_err_q != 16'hFFFF)     stat_err_q  <= stat_err_q + 16'd1;
    end
  end

  assign stat_pkts_rx = stat_pkts_q;
  assign stat_err     = stat_err_q;
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed vector table, hand-written corner
// sequences and random traffic checked against a packet-queue model.
module tb_router_input_buffer;
  import router_pkg::*;

  localparam int D = IBUF_DEPTH_PKTS * NUM_OF_FLITS;

  logic           clk = 1'b0;
  logic           rst_n;
  FLIT_t          in_flit;
  logic           in_ready;
  FLIT_t          out_flit;
  logic           out_req;
  logic           out_ack;
  logic [15:0]    route_addr;
  BUFFER_STATUS_t buf_status;
  logic           err_seq;
`ifdef ROUTER_IBUF_STATS_EN
  logic [15:0]    stat_pkts_rx;
  logic [15:0]    stat_err;
`endif

  router_input_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_req    (out_req),
    .out_ack    (out_ack),
    .route_addr (route_addr),
    .buf_status (buf_status),
`ifdef ROUTER_IBUF_STATS_EN
    .stat_pkts_rx (stat_pkts_rx),
    .stat_err     (stat_err),
`endif
    .err_seq    (err_seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed flits waiting to leave, plus the packet being
  // received. The output side only ever sees exp_q.
  logic [FLIT_SIZE-1:0] exp_q[$];
  logic [FLIT_SIZE-1:0] part_q[$];
  bit m_err;
  bit m_sent;
  int m_pkts;
  int m_errs;

  typedef struct {
    logic [FLIT_SIZE-1:0] flit;
    logic                 ack;
    logic                 exp_ready;
    logic                 exp_req;
    logic [FLIT_SIZE-1:0] exp_out;
    logic [15:0]          exp_route;
    BUFFER_STATUS_t       exp_status;
    logic                 exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_SIZE-1:0] mk(input logic v, input FLIT_TYPE_t t, input logic [15:0] d);
    return {v, t, d};
  endfunction

  function automatic FLIT_TYPE_t want_type();
    if (part_q.size() == 0) return HEAD_FLIT;
    if (part_q.size() == 3) return TAIL_FLIT;
    return BODY_FLIT;
  endfunction

  function automatic vec_t mkv(input logic [FLIT_SIZE-1:0] f, input logic a, input logic r,
                               input logic q, input logic [FLIT_SIZE-1:0] o, input logic [15:0] ra,
                               input BUFFER_STATUS_t s, input logic e);
    vec_t v;
    v.flit = f; v.ack = a; v.exp_ready = r; v.exp_req = q;
    v.exp_out = o; v.exp_route = ra; v.exp_status = s; v.exp_err = e;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    part_q.delete();
    m_err  = 1'b0;
    m_sent = 1'b0;
    m_pkts = 0;
    m_errs = 0;
  endtask

  task automatic drive(input logic [FLIT_SIZE-1:0] f, input logic ack);
    @(negedge clk);
    in_flit = FLIT_t'(f);
    out_ack = ack;
    #1;
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model
  // by the clock edge that follows.
  task automatic model_check(input logic [FLIT_SIZE-1:0] f, input logic ack);
    FLIT_t          fr;
    FLIT_t          fi;
    logic           e_req;
    logic           e_ready;
    int             free;
    logic [15:0]    e_route;
    BUFFER_STATUS_t e_st;
    bit             sent_n;
    FLIT_TYPE_t     want;
    e_req   = exp_q.size() > 0;
    free    = D - exp_q.size() - part_q.size();
    e_ready = (part_q.size() != 0) || (free >= NUM_OF_FLITS);
    fr      = e_req ? FLIT_t'(exp_q[0]) : '0;
    e_route = (e_req && fr.flit_type == HEAD_FLIT) ? fr.data : 16'h0;
    if (exp_q.size() > 0)       e_st = PACKET_RECEIVED;
    else if (part_q.size() > 0) e_st = PACKET_FILLING;
    else if (m_sent)            e_st = PACKET_SENT;
    else                        e_st = PACKET_EMPTY;
    chk("m_in_ready", in_ready, e_ready);
    chk("m_out_req", out_req, e_req);
    chk("m_out_flit", out_flit, fr);
    chk("m_route_addr", route_addr, e_route);
    chk("m_buf_status", buf_status, e_st);
    chk("m_err_seq", err_seq, m_err);
`ifdef ROUTER_IBUF_STATS_EN
    chk("m_stat_pkts_rx", stat_pkts_rx, m_pkts);
    chk("m_stat_err", stat_err, m_errs);
`endif
    sent_n = 1'b0;
    if (ack && e_req) begin
      if (fr.flit_type == TAIL_FLIT) sent_n = 1'b1;
      void'(exp_q.pop_front());
    end
    m_sent = sent_n;
    m_err  = 1'b0;
    fi = FLIT_t'(f);
    if (fi.valid && e_ready) begin
      want = want_type();
      if (fi.flit_type == want) begin
        part_q.push_back(f);
        if (want == TAIL_FLIT) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          if (m_pkts < 16'hFFFF) m_pkts++;
        end
      end else begin
        m_err = 1'b1;
        if (m_errs < 16'hFFFF) m_errs++;
        part_q.delete();
        if (fi.flit_type == HEAD_FLIT) part_q.push_back(f);
      end
    end
  endtask

  task automatic step(input logic [FLIT_SIZE-1:0] f, input logic ack);
    drive(f, ack);
    model_check(f, ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_req"}, out_req, 1'b0);
    chk({tag, "_out_flit"}, out_flit, '0);
    chk({tag, "_route_addr"}, route_addr, 16'h0);
    chk({tag, "_buf_status"}, buf_status, PACKET_EMPTY);
    chk({tag, "_err_seq"}, err_seq, 1'b0);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [FLIT_SIZE-1:0] idle;
    logic [FLIT_SIZE-1:0] h12, baa, bbb, tcc, h44, b55, b66, t77;
    logic [FLIT_SIZE-1:0] f;
    FLIT_TYPE_t t;
    int ack_pct;

    idle = '0;
    h12 = mk(1, HEAD_FLIT, 16'h0012); baa = mk(1, BODY_FLIT, 16'hAAAA);
    bbb = mk(1, BODY_FLIT, 16'hBBBB); tcc = mk(1, TAIL_FLIT, 16'hCCCC);
    h44 = mk(1, HEAD_FLIT, 16'h0044); b55 = mk(1, BODY_FLIT, 16'h5555);
    b66 = mk(1, BODY_FLIT, 16'h6666); t77 = mk(1, TAIL_FLIT, 16'h7777);

    // Basic packet in and out.
    vt.push_back(mkv(h12,  0, 1, 0, '0,  16'h0,    PACKET_EMPTY,    0));
    vt.push_back(mkv(baa,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(bbb,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(tcc,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(idle, 1, 1, 1, h12, 16'h0012, PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, baa, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, bbb, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, tcc, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 0, 1, 0, '0,  16'h0,    PACKET_SENT,     0));
    vt.push_back(mkv(idle, 0, 1, 0, '0,  16'h0,    PACKET_EMPTY,    0));
    // HEAD, BODY, TAIL: sequence error, partial packet discarded.
    vt.push_back(mkv(mk(1, HEAD_FLIT, 16'h0021), 0, 1, 0, '0, 16'h0, PACKET_EMPTY,   0));
    vt.push_back(mkv(mk(1, BODY_FLIT, 16'h1111), 0, 1, 0, '0, 16'h0, PACKET_FILLING, 0));
    vt.push_back(mkv(mk(1, TAIL_FLIT, 16'h2222), 0, 1, 0, '0, 16'h0, PACKET_FILLING, 0));
    vt.push_back(mkv(idle, 0, 1, 0, '0, 16'h0, PACKET_EMPTY, 1));
    vt.push_back(mkv(idle, 0, 1, 0, '0, 16'h0, PACKET_EMPTY, 0));
    // HEAD, BODY, BODY, HEAD: the second head restarts the packet.
    vt.push_back(mkv(mk(1, HEAD_FLIT, 16'h0031), 0, 1, 0, '0, 16'h0, PACKET_EMPTY,   0));
    vt.push_back(mkv(mk(1, BODY_FLIT, 16'h3333), 0, 1, 0, '0, 16'h0, PACKET_FILLING, 0));
    vt.push_back(mkv(mk(1, BODY_FLIT, 16'h4444), 0, 1, 0, '0, 16'h0, PACKET_FILLING, 0));
    vt.push_back(mkv(h44,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(b55,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  1));
    vt.push_back(mkv(b66,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(t77,  0, 1, 0, '0,  16'h0,    PACKET_FILLING,  0));
    vt.push_back(mkv(idle, 1, 1, 1, h44, 16'h0044, PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, b55, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, b66, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 1, 1, 1, t77, 16'h0,    PACKET_RECEIVED, 0));
    vt.push_back(mkv(idle, 0, 1, 0, '0,  16'h0,    PACKET_SENT,     0));
    vt.push_back(mkv(idle, 0, 1, 0, '0,  16'h0,    PACKET_EMPTY,    0));

    // Clock/reset.
    rst_n   = 1'b0;
    in_flit = '0;
    out_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].flit, vt[i].ack);
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].exp_ready);
      chk($sformatf("v%0d_out_req", i), out_req, vt[i].exp_req);
      chk($sformatf("v%0d_out_flit", i), out_flit, vt[i].exp_out);
      chk($sformatf("v%0d_route_addr", i), route_addr, vt[i].exp_route);
      chk($sformatf("v%0d_buf_status", i), buf_status, vt[i].exp_status);
      chk($sformatf("v%0d_err_seq", i), err_seq, vt[i].exp_err);
      model_check(vt[i].flit, vt[i].ack);
    end

    // Fill to capacity, pop one packet, then a third packet goes in while
    // the second is drained.
    for (int p = 0; p < IBUF_DEPTH_PKTS; p++) begin
      step(mk(1, HEAD_FLIT, 16'h0100 + 16'(p)), 0);
      step(mk(1, BODY_FLIT, 16'h1100 + 16'(p)), 0);
      step(mk(1, BODY_FLIT, 16'h2100 + 16'(p)), 0);
      step(mk(1, TAIL_FLIT, 16'h3100 + 16'(p)), 0);
    end
    step(idle, 0);
    chk("full_in_ready", in_ready, 1'b0);
    for (int k = 0; k < NUM_OF_FLITS; k++) step(mk(1, HEAD_FLIT, 16'h0177), 1);
    step(mk(1, HEAD_FLIT, 16'h0177), 1);
    chk("after_tail_pop_in_ready", in_ready, 1'b1);
    step(mk(1, BODY_FLIT, 16'h1177), 1);
    step(mk(1, BODY_FLIT, 16'h2177), 1);
    step(mk(1, TAIL_FLIT, 16'h3177), 1);
    for (int k = 0; k < 8; k++) step(idle, 1);
    step(idle, 0);

    // Reset mid-packet with one complete packet stored.
    step(mk(1, HEAD_FLIT, 16'h0055), 0);
    step(mk(1, BODY_FLIT, 16'h1055), 0);
    step(mk(1, BODY_FLIT, 16'h2055), 0);
    step(mk(1, TAIL_FLIT, 16'h3055), 0);
    step(mk(1, HEAD_FLIT, 16'h0066), 0);
    step(mk(1, BODY_FLIT, 16'h1066), 0);
    chk("pre_reset_out_req", out_req, 1'b1);
    rst_n   = 1'b0;
    in_flit = '0;
    out_ack = 1'b0;
    #2;
    check_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(idle, 0);
    chk("post_reset_status", buf_status, PACKET_EMPTY);

    // Two stray flits and three good packets for the counters.
    step(mk(1, BODY_FLIT, 16'hDEAD), 1);
    step(mk(1, NONE_FLIT, 16'hBEEF), 1);
    for (int p = 0; p < 3; p++) begin
      step(mk(1, HEAD_FLIT, 16'h0200 + 16'(p)), 1);
      step(mk(1, BODY_FLIT, 16'h1200 + 16'(p)), 1);
      step(mk(1, BODY_FLIT, 16'h2200 + 16'(p)), 1);
      step(mk(1, TAIL_FLIT, 16'h3200 + 16'(p)), 1);
    end
    step(idle, 1);
`ifdef ROUTER_IBUF_STATS_EN
    chk("stat_pkts_rx_3", stat_pkts_rx, 16'd3);
    chk("stat_err_2", stat_err, 16'd2);
`endif
    for (int k = 0; k < 8; k++) step(idle, 1);

    // Random traffic with a varying drain rate so the buffer runs full.
    for (int blk = 0; blk < 10; blk++) begin
      ack_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 99) < 88) t = want_type();
        else t = FLIT_TYPE_t'($urandom_range(0, 3));
        f = mk($urandom_range(0, 99) < 85, t, 16'($urandom_range(0, 65535)));
        step(f, $urandom_range(0, 99) < ack_pct);
      end
    end
    for (int k = 0; k < 3 * D; k++) step(idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
